aes_block_loader: RTL and testbench

- Upstream input stage of the AES core.
- Accepts a 128-bit key or data block as four 32-bit words over a valid/ready stream, each word tagged with a 2-bit type.
- Assembles the block and presents it as one 128-bit word plus type and a valid strobe to key expansion (TYPE_KEY) or the cipher datapath (TYPE_DATA).
- Holds the block until the consumer accepts it.

---
 rtl/aes_pkg.sv | 15 +
 rtl/aes_block_loader.sv | 72 +++++++
 tb/tb_aes_block_loader.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: type codes and loader state encoding shared by the AES input stage and key expansion
package aes_pkg;
  localparam int WORD_W = 32;
  localparam logic [1:0] TYPE_NONE = 2'b00;
  localparam logic [1:0] TYPE_DATA = 2'b01;
  localparam logic [1:0] TYPE_KEY = 2'b10;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } ld_state_e;
  function automatic logic is_legal(input logic [1:0] t);
    return t == TYPE_KEY || t == TYPE_DATA;
  endfunction
endpackage

// File: rtl/aes_block_loader.sv
// aes_block_loader: packs four typed 32-bit stream words (s_*) into a 128-bit block (blk_*) held until blk_ready, with abort and err_type pulse
module aes_block_loader
  import aes_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [WORD_W-1:0]   s_data,
  input  logic [1:0]          s_type,
  input  logic                abort,
  output logic                blk_valid,
  input  logic                blk_ready,
  output logic [4*WORD_W-1:0] blk_data,
  output logic [1:0]          blk_type,
  output logic                err_type
);
  ld_state_e state;
  logic [1:0] cnt;
  logic acc;
  assign s_ready = state != HOLD;
  assign acc = s_valid && s_ready;
  always_ff @(posedge clk) begin
    err_type <= 1'b0;
    if (rst) begin
      state <= IDLE;
      cnt <= 2'd0;
      blk_valid <= 1'b0;
      blk_data <= '0;
      blk_type <= TYPE_NONE;
    end else if (abort) begin
      state <= IDLE;
      cnt <= 2'd0;
      blk_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (acc) begin
          if (is_legal(s_type)) begin
            blk_data[WORD_W-1:0] <= s_data;
            blk_type <= s_type;
            cnt <= 2'd1;
            state <= FILL;
          end else err_type <= 1'b1;
        end
        FILL: if (acc) begin
          if (s_type == blk_type) begin
            blk_data[{cnt, 5'd0} +: WORD_W] <= s_data;
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              state <= HOLD;
              blk_valid <= 1'b1;
            end
          end else if (is_legal(s_type)) begin
            err_type <= 1'b1;
            blk_data[WORD_W-1:0] <= s_data;
            blk_type <= s_type;
            cnt <= 2'd1;
          end else begin
            err_type <= 1'b1;
            cnt <= 2'd0;
            state <= IDLE;
          end
        end
        HOLD: if (blk_ready) begin
          state <= IDLE;
          blk_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_block_loader.sv
// tb_aes_block_loader: table-driven directed vectors plus hand sequences for the AES block loader
module tb_aes_block_loader;
  import aes_pkg::*;
  logic clk = 1'b0;
  logic rst, s_valid, s_ready, abort, blk_valid, blk_ready, err_type;
  logic [31:0] s_data;
  logic [1:0] s_type, blk_type;
  logic [127:0] blk_data;
  int n_chk = 0;
  int n_fail = 0;

  aes_block_loader dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_type(s_type), .abort(abort), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_data(blk_data), .blk_type(blk_type), .err_type(err_type)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic r, v, ab, br;
    logic [1:0] t;
    logic [31:0] d;
    logic er, ebv, eerr, ecd;
    logic [1:0] et;
    logic [127:0] ed;
  } vec_t;

  vec_t vq[$];

  localparam logic [1:0] K = 2'b10;
  localparam logic [1:0] D = 2'b01;
  localparam logic [1:0] X = 2'b11;

  function automatic vec_t mk(logic r, logic v, logic [1:0] t, logic [31:0] d, logic ab, logic br,
                              logic er, logic ebv, logic eerr, logic ecd, logic [1:0] et, logic [127:0] ed);
    vec_t x;
    x.r = r; x.v = v; x.t = t; x.d = d; x.ab = ab; x.br = br;
    x.er = er; x.ebv = ebv; x.eerr = eerr; x.ecd = ecd; x.et = et; x.ed = ed;
    return x;
  endfunction

  task automatic chk(input string name, input int idx, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [1:0] t, input logic [31:0] d,
                       input logic ab, input logic br);
    rst = r; s_valid = v; s_type = t; s_data = d; abort = ab; blk_ready = br;
  endtask

  localparam logic [127:0] KB1 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [127:0] DB2 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] DB3 = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
  localparam logic [127:0] KB4 = 128'hF3F3F3F3_F2F2F2F2_F1F1F1F1_F0F0F0F0;
  localparam logic [127:0] KB5 = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
  localparam logic [127:0] DB5 = 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0;
  localparam logic [127:0] DB6 = 128'h66666666_65656565_64646464_63636363;

  initial begin
    drive(1, 0, 0, 0, 0, 0);
    // reset
    vq.push_back(mk(1,0,0,0,0,0, 1,0,0,1,2'b00,'0));
    // key block, consumer ready
    vq.push_back(mk(0,1,K,32'h03020100,0,1, 1,0,0,0,0,'0));
    vq.push_back(mk(0,1,K,32'h07060504,0,1, 1,0,0,0,0,'0));
    vq.push_back(mk(0,1,K,32'h0B0A0908,0,1, 1,0,0,0,0,'0));
    vq.push_back(mk(0,1,K,32'h0F0E0D0C,0,1, 0,1,0,1,K,KB1));
    vq.push_back(mk(0,0,0,0,0,1, 1,0,0,1,K,KB1));
    // data block held five cycles with a fifth word offered
    vq.push_back(mk(0,1,D,32'h11111111,0,0, 1,0,0,0,0,'0));
    vq.push_back(mk(0,1,D,32'h22222222,0,0, 1,0,0,0,0,'0));
    vq.push_back(mk(0,1,D,32'h33333333,0,0, 1,0,0,0,0,'0));
    vq.push_back(mk(0,1,D,32'h44444444,0,0, 0,1,0,1,D,DB2));
    for (int i = 0; i < 4; i++) vq.push_back(mk(0,1,D,32'h55555555,0,0, 0,1,0,1,D,DB2));
    vq.push_back(mk(0,1,D,32'h55555555,0,1, 1,0,0,1,D,DB2));
    // type switch mid-fill restarts with the data word
    vq.push_back(mk(0,1,K,32'h01010101,0,0, 1,0,0,0,0,'0));
    vq.push_back(mk(0,1,K,32'h02020202,0,0, 1,0,0,0,0,'0));
    vq.push_back(mk(0,1,D,32'hAAAAAAAA,0,0, 1,0,1,0,0,'0));
    vq.push_back(mk(0,1,D,32'hBBBBBBBB,0,0, 1,0,0,0,0,'0));
    vq.push_back(mk(0,1,D,32'hCCCCCCCC,0,0, 1,0,0,0,0,'0));
    vq.push_back(mk(0,1,D,32'hDDDDDDDD,0,1, 0,1,0,1,D,DB3));
    vq.push_back(mk(0,0,0,0,0,1, 1,0,0,1,D,DB3));
    // illegal types in IDLE and in FILL
    vq.push_back(mk(0,1,X,32'h12345678,0,0, 1,0,1,0,0,'0));
    vq.push_back(mk(0,1,K,32'hE0E0E0E0,0,0, 1,0,0,0,0,'0));
    vq.push_back(mk(0,1,K,32'hE1E1E1E1,0,0, 1,0,0,0,0,'0));
    vq.push_back(mk(0,1,X,32'h99999999,0,0, 1,0,1,0,0,'0));
    vq.push_back(mk(0,1,K,32'hF0F0F0F0,0,0, 1,0,0,0,0,'0));
    vq.push_back(mk(0,1,K,32'hF1F1F1F1,0,0, 1,0,0,0,0,'0));
    vq.push_back(mk(0,1,K,32'hF2F2F2F2,0,0, 1,0,0,0,0,'0));
    vq.push_back(mk(0,1,K,32'hF3F3F3F3,0,0, 0,1,0,1,K,KB4));
    vq.push_back(mk(0,0,0,0,0,1, 1,0,0,1,K,KB4));
    // abort mid-fill, then abort against blk_ready in HOLD
    vq.push_back(mk(0,1,K,32'hA1A1A1A1,0,0, 1,0,0,0,0,'0));
    vq.push_back(mk(0,1,K,32'hA2A2A2A2,0,0, 1,0,0,0,0,'0));
    vq.push_back(mk(0,1,K,32'hA3A3A3A3,0,0, 1,0,0,0,0,'0));
    vq.push_back(mk(0,1,K,32'hA4A4A4A4,1,0, 1,0,0,0,0,'0));
    vq.push_back(mk(0,1,K,32'hB0B0B0B0,0,0, 1,0,0,0,0,'0));
    vq.push_back(mk(0,1,K,32'hB1B1B1B1,0,0, 1,0,0,0,0,'0));
    vq.push_back(mk(0,1,K,32'hB2B2B2B2,0,0, 1,0,0,0,0,'0));
    vq.push_back(mk(0,1,K,32'hB3B3B3B3,0,0, 0,1,0,1,K,KB5));
    vq.push_back(mk(0,0,0,0,1,1, 1,0,0,0,0,'0));
    vq.push_back(mk(0,1,D,32'hC0C0C0C0,0,0, 1,0,0,0,0,'0));
    vq.push_back(mk(0,1,D,32'hC1C1C1C1,0,0, 1,0,0,0,0,'0));
    vq.push_back(mk(0,1,D,32'hC2C2C2C2,0,0, 1,0,0,0,0,'0));
    vq.push_back(mk(0,1,D,32'hC3C3C3C3,0,1, 0,1,0,1,D,DB5));
    vq.push_back(mk(0,0,0,0,0,1, 1,0,0,1,D,DB5));
    // reset mid-fill with a word offered
    vq.push_back(mk(0,1,K,32'hD0D0D0D0,0,0, 1,0,0,0,0,'0));
    vq.push_back(mk(0,1,K,32'hD1D1D1D1,0,0, 1,0,0,0,0,'0));
    vq.push_back(mk(1,1,K,32'hD2D2D2D2,0,0, 1,0,0,1,2'b00,'0));
    vq.push_back(mk(0,0,0,0,0,0, 1,0,0,1,2'b00,'0));

    foreach (vq[i]) begin
      drive(vq[i].r, vq[i].v, vq[i].t, vq[i].d, vq[i].ab, vq[i].br);
      @(posedge clk); #1;
      chk("s_ready", i, 128'(s_ready), 128'(vq[i].er));
      chk("blk_valid", i, 128'(blk_valid), 128'(vq[i].ebv));
      chk("err_type", i, 128'(err_type), 128'(vq[i].eerr));
      if (vq[i].ecd) begin
        chk("blk_data", i, blk_data, vq[i].ed);
        chk("blk_type", i, 128'(blk_type), 128'(vq[i].et));
      end
    end

    // err_type is a single-cycle pulse for one offending word
    drive(0, 1, X, 32'h0BADF00D, 0, 0);
    @(posedge clk); #1;
    chk("err_pulse_hi", 100, 128'(err_type), 128'(1));
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("err_pulse_lo", 101, 128'(err_type), 128'(0));

    // back-to-back: word accepted in the first cycle after handoff, bounded release wait
    for (int w = 0; w < 4; w++) begin
      drive(0, 1, D, 32'h63636363 + 32'h01010101 * w, 0, 0);
      @(posedge clk); #1;
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("lat_valid", 102, 128'(blk_valid), 128'(1));
    chk("lat_data", 103, blk_data, DB6);
    @(negedge clk);
    chk("hold_ready", 104, 128'(s_ready), 128'(0));
    drive(0, 0, 0, 0, 0, 1);
    begin
      int c = 0;
      while (blk_valid && c < 4) begin
        @(posedge clk); #1;
        c++;
      end
      chk("release_timeout", 105, 128'(blk_valid), 128'(0));
      chk("release_cycles", 106, 128'(c), 128'(1));
    end
    drive(0, 1, K, 32'h77777777, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    chk("restart_ready", 107, 128'(s_ready), 128'(1));
    chk("restart_no_err", 108, 128'(err_type), 128'(0));
    chk("restart_type", 109, 128'(blk_type), 128'(K));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
